valu4_scheduler: RTL and testbench

- Shares one VectorALU4 instance between two requester ports (port 0, port 1) under round-robin arbitration.
- Registers the accepted operands and opcode, then drives the ALU for a fixed number of cycles per opcode class.
- Captures Y or Y2 and returns a tagged 8-bit response over a valid/ready handshake.
- Serves the multiply-MSW opcode from its own saved product register, so results never depend on stale ALU-internal state.

---
 rtl/valu4_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_valu4_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/valu4_scheduler.sv
`default_nettype none
//============================================================================
// Module      : valu4_scheduler
// Description : Round-robin scheduler sharing one VectorALU4 between two
//               requester ports. Latches the winning request, holds the ALU
//               inputs for a per-opcode-class number of cycles, captures Y or
//               Y2 and returns a tagged 8-bit response over valid/ready.
//               The multiply-MSW opcode is served from a locally saved
//               product, never from ALU-internal state.
// Revision    : 1.0 - initial release
//============================================================================
module valu4_scheduler #(
    parameter int EXEC_CYCLES = 1,
    parameter int MUL_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    // requester port 0
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [4:0] req0_op,
    input  logic [3:0] req0_r,
    input  logic [3:0] req0_s,
    // requester port 1
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [4:0] req1_op,
    input  logic [3:0] req1_r,
    input  logic [3:0] req1_s,
    // shared ALU
    output logic [3:0] alu_r,
    output logic [3:0] alu_s,
    output logic [4:0] alu_op,
    input  logic [3:0] alu_y,
    input  logic [7:0] alu_y2,
    // response
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    localparam logic [4:0] c_op_idle = 5'b00001;  // pass-S while nothing runs
    localparam logic [4:0] c_op_mul  = 5'b01000;
    localparam logic [4:0] c_op_msw  = 5'b01001;

    localparam logic [3:0] c_exec_cnt = 4'(EXEC_CYCLES);
    localparam logic [3:0] c_mul_cnt  = 4'(MUL_CYCLES);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    logic [4:0] r_op;
    logic [3:0] r_r;
    logic [3:0] r_s;
    logic [3:0] r_cnt;
    logic       r_rr_ptr;
    logic [7:0] r_last_product;
    logic       r_rsp_id;
    logic [7:0] r_rsp_data;
    logic       r_rsp_err;

    logic       w_any_req;
    logic       w_gnt_id;
    logic       w_accept;
    logic [4:0] w_sel_op;
    logic [3:0] w_sel_r;
    logic [3:0] w_sel_s;
    logic       w_sel_is_mul;
    logic       w_sel_is_msw;
    logic       w_sel_is_alu;
    logic       w_exec_done;

    // Arbitration: sole valid port wins, a tie goes to the round-robin pointer
    assign w_any_req = req0_valid | req1_valid;
    assign w_gnt_id  = (req0_valid & req1_valid) ? r_rr_ptr : req1_valid;
    assign w_accept  = (r_state == c_st_idle) & w_any_req;

    assign w_sel_op  = w_gnt_id ? req1_op : req0_op;
    assign w_sel_r   = w_gnt_id ? req1_r  : req0_r;
    assign w_sel_s   = w_gnt_id ? req1_s  : req0_s;

    // Opcode classes: ALU ops, multiply, internal MSW, everything else unsupported
    assign w_sel_is_mul = (w_sel_op == c_op_mul);
    assign w_sel_is_msw = (w_sel_op == c_op_msw);
    assign w_sel_is_alu = (w_sel_op <= 5'b00111) | (w_sel_op == 5'b01010) |
                          (w_sel_op == 5'b01011);

    // A zero count can only arise from an out-of-range parameter; treat it as done
    assign w_exec_done = (r_state == c_st_exec) & (r_cnt <= 4'd1);

    // ALU operands always come from the latched request, never from the ports
    assign alu_r     = r_r;
    assign alu_s     = r_s;

    assign rsp_valid = (r_state == c_st_resp);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != c_st_idle);

    // The low nibble of the saved product is never returned by the MSW op
    logic w_unused_lsbs;
    assign w_unused_lsbs = &{1'b0, r_last_product[3:0]};

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, request readies and ALU opcode drive
    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        alu_op      = c_op_idle;
        case (r_state)
            c_st_idle: begin
                req0_ready = w_any_req & ~w_gnt_id;
                req1_ready = w_any_req &  w_gnt_id;
                if (w_any_req) begin
                    w_state_nxt = (w_sel_is_alu | w_sel_is_mul) ? c_st_exec : c_st_resp;
                end
            end
            c_st_exec: begin
                alu_op = r_op;
                if (w_exec_done) begin
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: begin
                if (rsp_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Request latch, execution counter, result capture and saved product
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_op           <= c_op_idle;
            r_r            <= 4'h0;
            r_s            <= 4'h0;
            r_cnt          <= 4'h0;
            r_rr_ptr       <= 1'b0;
            r_last_product <= 8'h00;
            r_rsp_id       <= 1'b0;
            r_rsp_data     <= 8'h00;
            r_rsp_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= w_sel_op;
                r_r      <= w_sel_r;
                r_s      <= w_sel_s;
                r_rsp_id <= w_gnt_id;
                r_rr_ptr <= ~w_gnt_id;
                r_cnt    <= w_sel_is_mul ? c_mul_cnt : c_exec_cnt;
                if (w_sel_is_msw) begin
                    r_rsp_data <= {4'h0, r_last_product[7:4]};
                    r_rsp_err  <= 1'b0;
                end else if (!(w_sel_is_alu | w_sel_is_mul)) begin
                    r_rsp_data <= 8'h00;
                    r_rsp_err  <= 1'b1;
                end else begin
                    r_rsp_err  <= 1'b0;
                end
            end
            if (r_state == c_st_exec) begin
                r_cnt <= r_cnt - 4'd1;
                if (w_exec_done) begin
                    if (r_op == c_op_mul) begin
                        r_rsp_data     <= alu_y2;
                        r_last_product <= alu_y2;
                    end else begin
                        r_rsp_data     <= {4'h0, alu_y};
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_valu4_scheduler.sv
`default_nettype none
//============================================================================
// Module      : tb_valu4_scheduler
// Description : Self-checking bench for valu4_scheduler with a behavioural
//               ALU stand-in and a reference model of arbitration/results.
// Revision    : 1.0 - initial release
//============================================================================
module tb_valu4_scheduler;

    localparam int E = 2;
    localparam int M = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [4:0] req0_op = 5'd0, req1_op = 5'd0;
    logic [3:0] req0_r = 4'd0, req0_s = 4'd0, req1_r = 4'd0, req1_s = 4'd0;
    logic [3:0] alu_r, alu_s, alu_y;
    logic [4:0] alu_op;
    logic [7:0] alu_y2;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err, busy;
    logic [7:0] rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int         model_rr   = 0;
    logic [7:0] model_last = 8'h00;
    int         bad_alu_op = 0;

    valu4_scheduler #(.EXEC_CYCLES(E), .MUL_CYCLES(M)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_r(req0_r), .req0_s(req0_s),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_r(req1_r), .req1_s(req1_s),
        .alu_r(alu_r), .alu_s(alu_s), .alu_op(alu_op), .alu_y(alu_y), .alu_y2(alu_y2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU results
    function automatic logic [3:0] ref_y(input logic [4:0] op, input logic [3:0] r, input logic [3:0] s);
        int a, b, sum;
        case (op)
            5'b00000: ref_y = r + s;
            5'b00001: ref_y = s;
            5'b00010: ref_y = r - s;
            5'b00110: begin
                a = $signed(r); b = $signed(s); sum = a + b;
                if (sum > 7)  sum = 7;
                if (sum < -8) sum = -8;
                ref_y = 4'(sum);
            end
            default:  ref_y = (r ^ {s[0], s[3:1]}) ^ op[3:0];
        endcase
    endfunction

    function automatic logic [7:0] ref_prod(input logic [3:0] r, input logic [3:0] s);
        int a, b;
        a = $signed(r); b = $signed(s);
        ref_prod = 8'(a * b);
    endfunction

    // ALU stand-in: results are only correct once the inputs have been held
    // long enough; an early capture sees the inverted (wrong) value.
    logic [12:0] alu_prev = 13'h1fff;
    int          held = 0;
    always @(negedge clk) begin
        if ({alu_op, alu_r, alu_s} == alu_prev) held++;
        else held = 1;
        alu_prev = {alu_op, alu_r, alu_s};
        alu_y  = (held >= E) ? ref_y(alu_op, alu_r, alu_s) : ~ref_y(alu_op, alu_r, alu_s);
        alu_y2 = (held >= M) ? ref_prod(alu_r, alu_s)       : ~ref_prod(alu_r, alu_s);
        if (alu_op == 5'b01001 || alu_op >= 5'b01100) bad_alu_op++;
    end

    // Expected response; lat = rising edges after the accept edge before
    // rsp_valid is seen (internal/unsupported ops respond on the accept edge)
    task automatic model_rsp(input logic [4:0] op, input logic [3:0] r, input logic [3:0] s,
                             output logic [7:0] d, output logic e, output int lat);
        if (op == 5'b01000) begin
            d = ref_prod(r, s); e = 1'b0; lat = M; model_last = d;
        end else if (op == 5'b01001) begin
            d = {4'h0, model_last[7:4]}; e = 1'b0; lat = 0;
        end else if (op >= 5'b01100) begin
            d = 8'h00; e = 1'b1; lat = 0;
        end else begin
            d = {4'h0, ref_y(op, r, s)}; e = 1'b0; lat = E;
        end
    endtask

    task automatic set_req(input int port, input logic [4:0] op, input logic [3:0] r, input logic [3:0] s);
        if (port == 0) begin req0_valid = 1'b1; req0_op = op; req0_r = r; req0_s = s; end
        else           begin req1_valid = 1'b1; req1_op = op; req1_r = r; req1_s = s; end
    endtask

    // Returns at the negedge after the accept edge; port = -1 on timeout
    task automatic wait_accept(output int port);
        int waited;
        port = -1; waited = 0;
        while (port < 0 && waited < 40) begin
            #1;
            if (req0_valid && req0_ready)      port = 0;
            else if (req1_valid && req1_ready) port = 1;
            @(negedge clk);
            if (port == 0)      req0_valid = 1'b0;
            else if (port == 1) req1_valid = 1'b0;
            else                waited++;
        end
        if (port >= 0) model_rr = (port == 0) ? 1 : 0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({rsp_valid, busy, rsp_id, rsp_err, req0_ready, req1_ready} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000000", {rsp_valid, busy, rsp_id, rsp_err, req0_ready, req1_ready});
        end
        n_tests++;
        if ({alu_op, alu_r, alu_s, rsp_data} !== {5'b00001, 4'h0, 4'h0, 8'h00}) begin
            n_fail++; $display("FAIL reset_data: alu_op=%b r=%h s=%h data=%h want 00001/0/0/00", alu_op, alu_r, alu_s, rsp_data);
        end
        reset_n = 1'b1;
        model_rr = 0; model_last = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_rr_tie();
        int port, lat, xl;
        logic [7:0] xd; logic xe;
        set_req(0, 5'b00000, 4'd3, 4'd4);
        set_req(1, 5'b00010, 4'd9, 4'd2);
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL rr_first_ready: got %b want 10", {req0_ready, req1_ready});
        end
        wait_accept(port);
        model_rsp(5'b00000, 4'd3, 4'd4, xd, xe, xl);
        wait_rsp(lat);
        n_tests++;
        if (port !== 0 || rsp_id !== 1'b0 || rsp_data !== 8'h07 || xd !== 8'h07) begin
            n_fail++; $display("FAIL rr_first_rsp: port=%0d id=%b data=%h want 0/0/07", port, rsp_id, rsp_data);
        end
        handshake();
        wait_accept(port);
        model_rsp(5'b00010, 4'd9, 4'd2, xd, xe, xl);
        wait_rsp(lat);
        n_tests++;
        if (port !== 1 || rsp_id !== 1'b1 || rsp_data !== xd) begin
            n_fail++; $display("FAIL rr_second_rsp: port=%0d id=%b data=%h want 1/1/%h", port, rsp_id, rsp_data, xd);
        end
        handshake();
        set_req(0, 5'b00000, 4'd1, 4'd1);
        set_req(1, 5'b00000, 4'd2, 4'd2);
        wait_accept(port);
        req1_valid = 1'b0;
        n_tests++;
        if (port !== 0) begin
            n_fail++; $display("FAIL rr_third_grant: got port %0d want 0", port);
        end
        model_rsp(5'b00000, 4'd1, 4'd1, xd, xe, xl);
        wait_rsp(lat);
        handshake();
    endtask

    task automatic test_sat_add();
        int port, lat, xl;
        logic [7:0] xd; logic xe;
        set_req(0, 5'b00110, 4'h6, 4'h5);
        wait_accept(port);
        model_rsp(5'b00110, 4'h6, 4'h5, xd, xe, xl);
        wait_rsp(lat);
        n_tests++;
        if (rsp_data !== 8'h07 || xd !== 8'h07 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL sat_add_data: data=%h err=%b want 07/0", rsp_data, rsp_err);
        end
        n_tests++;
        if (lat !== xl) begin
            n_fail++; $display("FAIL sat_add_latency: got %0d want %0d", lat, xl);
        end
        handshake();
    endtask

    task automatic test_mul_msw();
        int port, lat, xl, bad0;
        logic [7:0] xd; logic xe;
        bad0 = bad_alu_op;
        set_req(1, 5'b01000, 4'hD, 4'h5);
        wait_accept(port);
        model_rsp(5'b01000, 4'hD, 4'h5, xd, xe, xl);
        wait_rsp(lat);
        n_tests++;
        if (rsp_data !== 8'hF1 || xd !== 8'hF1 || rsp_id !== 1'b1 || lat !== xl) begin
            n_fail++; $display("FAIL mul_rsp: data=%h id=%b lat=%0d want F1/1/%0d", rsp_data, rsp_id, lat, xl);
        end
        handshake();
        set_req(1, 5'b01001, 4'h0, 4'h0);
        wait_accept(port);
        model_rsp(5'b01001, 4'h0, 4'h0, xd, xe, xl);
        wait_rsp(lat);
        n_tests++;
        if (rsp_data !== 8'h0F || rsp_err !== 1'b0 || lat !== xl) begin
            n_fail++; $display("FAIL msw_rsp: data=%h err=%b lat=%0d want 0F/0/%0d", rsp_data, rsp_err, lat, xl);
        end
        handshake();
        n_tests++;
        if (bad_alu_op !== bad0) begin
            n_fail++; $display("FAIL msw_alu_op: saw %0d forbidden alu_op cycles want 0", bad_alu_op - bad0);
        end
    endtask

    task automatic test_backpressure();
        int port, lat, xl, errs;
        logic [7:0] xd; logic xe;
        set_req(0, 5'b00000, 4'h2, 4'h5);
        wait_accept(port);
        model_rsp(5'b00000, 4'h2, 4'h5, xd, xe, xl);
        wait_rsp(lat);
        set_req(1, 5'b00000, 4'h1, 4'h1);
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rsp_valid !== 1'b1 || rsp_data !== xd || rsp_id !== 1'b0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) errs++;
            @(negedge clk);
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++; $display("FAIL backpressure_hold: %0d unstable cycles want 0 (data=%h want %h)", errs, rsp_data, xd);
        end
        rsp_ready = 1'b1;
        #1;
        n_tests++;
        if (req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL handshake_no_accept: req1_ready=%b want 0", req1_ready);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        n_tests++;
        if (rsp_valid !== 1'b0 || alu_op !== 5'b00001) begin
            n_fail++; $display("FAIL backpressure_release: valid=%b alu_op=%b want 0/00001", rsp_valid, alu_op);
        end
        wait_accept(port);
        model_rsp(5'b00000, 4'h1, 4'h1, xd, xe, xl);
        wait_rsp(lat);
        n_tests++;
        if (port !== 1 || rsp_data !== xd) begin
            n_fail++; $display("FAIL backpressure_next: port=%0d data=%h want 1/%h", port, rsp_data, xd);
        end
        handshake();
    endtask

    task automatic test_unsupported();
        int port, lat, xl;
        logic [7:0] xd; logic xe;
        set_req(0, 5'b11111, 4'h5, 4'h6);
        wait_accept(port);
        model_rsp(5'b11111, 4'h5, 4'h6, xd, xe, xl);
        wait_rsp(lat);
        n_tests++;
        if (rsp_err !== 1'b1 || rsp_data !== 8'h00 || lat !== xl || alu_op !== 5'b00001) begin
            n_fail++; $display("FAIL unsupported: err=%b data=%h lat=%0d alu_op=%b want 1/00/%0d/00001", rsp_err, rsp_data, lat, xl, alu_op);
        end
        handshake();
    endtask

    task automatic test_reset_mid_exec();
        int port, lat, xl;
        logic [7:0] xd; logic xe;
        set_req(1, 5'b01000, 4'h7, 4'h7);
        wait_accept(port);
        reset_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({rsp_valid, busy, rsp_id, rsp_err, alu_op, alu_r, alu_s, rsp_data} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 5'b00001, 4'h0, 4'h0, 8'h00}) begin
            n_fail++; $display("FAIL reset_mid_exec: valid=%b busy=%b id=%b err=%b op=%b r=%h s=%h data=%h want all reset values",
                               rsp_valid, busy, rsp_id, rsp_err, alu_op, alu_r, alu_s, rsp_data);
        end
        reset_n = 1'b1;
        model_rr = 0; model_last = 8'h00;
        repeat (4) @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_rsp: rsp_valid=%b want 0", rsp_valid);
        end
        set_req(0, 5'b01001, 4'h0, 4'h0);
        wait_accept(port);
        model_rsp(5'b01001, 4'h0, 4'h0, xd, xe, xl);
        wait_rsp(lat);
        n_tests++;
        if (rsp_data !== 8'h00 || xd !== 8'h00) begin
            n_fail++; $display("FAIL msw_after_reset: data=%h want 00", rsp_data);
        end
        handshake();
    endtask

    task automatic test_random();
        int port, lat, xl, mask, win, errs;
        logic [7:0] xd; logic xe;
        logic [4:0] op0, op1;
        logic [3:0] r0, s0, r1, s1;
        errs = 0;
        for (int i = 0; i < 60; i++) begin
            mask = $urandom_range(1, 3);
            op0 = ($urandom_range(0, 3) == 0) ? 5'(8 + $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
            op1 = ($urandom_range(0, 3) == 0) ? 5'(8 + $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
            r0 = 4'($urandom); s0 = 4'($urandom); r1 = 4'($urandom); s1 = 4'($urandom);
            if (mask[0]) set_req(0, op0, r0, s0);
            if (mask[1]) set_req(1, op1, r1, s1);
            win = (mask == 3) ? model_rr : (mask == 2 ? 1 : 0);
            wait_accept(port);
            req0_valid = 1'b0; req1_valid = 1'b0;
            if (win == 0) model_rsp(op0, r0, s0, xd, xe, xl);
            else          model_rsp(op1, r1, s1, xd, xe, xl);
            wait_rsp(lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            n_tests++;
            if (port !== win || rsp_id !== 1'(win) || rsp_data !== xd || rsp_err !== xe || lat !== xl) begin
                n_fail++; errs++;
                $display("FAIL random_%0d: port=%0d id=%b data=%h err=%b lat=%0d want %0d/%0d/%h/%b/%0d",
                         i, port, rsp_id, rsp_data, rsp_err, lat, win, win, xd, xe, xl);
            end
            handshake();
            if (errs > 5) break;
        end
    endtask

    initial begin
        int bad0;
        test_reset();
        bad0 = bad_alu_op;
        test_rr_tie();
        test_sat_add();
        test_mul_msw();
        test_backpressure();
        test_unsupported();
        test_reset_mid_exec();
        test_random();
        n_tests++;
        if (bad_alu_op !== bad0) begin
            n_fail++; $display("FAIL alu_op_guard: %0d forbidden alu_op cycles want 0", bad_alu_op - bad0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
